fifo_flagged: RTL and testbench

//  Parametrised synchronous FIFO, successor to the basic CPU FIFO: same push/pop

---
 rtl/fifo_flagged_pkg.sv | 31 +++
 rtl/fifo_flagged_if.sv | 29 ++
 rtl/fifo_flagged_mem.sv | 26 ++
 rtl/fifo_flagged.sv | 113 +++++++++++
 tb/tb_fifo_flagged.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/fifo_flagged_pkg.sv
// Shared constants for fifo_flagged: status/error bit indices, flag bundle
// and elaboration helpers.
package fifo_flagged_pkg;

    localparam int unsigned ERR_OVF_BIT = 0;
    localparam int unsigned ERR_UDF_BIT = 1;
    localparam int unsigned ERR_W       = 2;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_full;
        logic almost_empty;
    } flags_t;

    function automatic bit is_pow2(input int unsigned x);
        return (x != 32'd0) && ((x & (x - 32'd1)) == 32'd0);
    endfunction

    // Every occupancy flag is a pure function of the entry count.
    function automatic flags_t fifo_flags(input int unsigned cnt, input int unsigned length,
                                          input int unsigned af, input int unsigned ae);
        flags_t f;
        f.empty        = (cnt == 32'd0);
        f.full         = (cnt == length);
        f.almost_full  = (cnt >= af);
        f.almost_empty = (cnt <= ae);
        return f;
    endfunction

endpackage

// File: rtl/fifo_flagged_if.sv
// Push/pop/status bundle for fifo_flagged; master drives requests, slave is the FIFO.
interface fifo_flagged_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned CW   = 4
);
    logic            we;
    logic            re;
    logic [XLEN-1:0] din;
    logic            clearErr;
    logic [XLEN-1:0] dout;
    logic            dvalid;
    logic            empty;
    logic            full;
    logic            almostFull;
    logic            almostEmpty;
    logic [CW-1:0]   count;
    logic            overflow;
    logic            underflow;

    modport master (
        output we, re, din, clearErr,
        input  dout, dvalid, empty, full, almostFull, almostEmpty, count, overflow, underflow
    );

    modport slave (
        input  we, re, din, clearErr,
        output dout, dvalid, empty, full, almostFull, almostEmpty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_flagged_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port.
module fifo_mem #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned LENGTH = 8,
    parameter int unsigned AW     = $clog2(LENGTH)
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [XLEN-1:0] rdata_o
);

    logic [XLEN-1:0] mem_q [LENGTH];

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_flagged.sv
// Synchronous FIFO with registered occupancy flags, sticky overflow/underflow
// and selectable first-word-fall-through or registered read.
module fifo_flagged
    import fifo_flagged_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned LENGTH       = 8,
    parameter int unsigned FWFT         = 1,
    parameter int unsigned ALMOST_FULL  = LENGTH - 1,
    parameter int unsigned ALMOST_EMPTY = 1
) (
    input  logic          clk,
    input  logic          reset,
    fifo_flagged_if.slave bus
);

    localparam int unsigned AW = $clog2(LENGTH);
    localparam int unsigned PW = AW + 1;

    if (!is_pow2(LENGTH) || LENGTH < 2) begin : g_bad_length
        $error("fifo_flagged: LENGTH must be a power of two >= 2");
    end
    if (ALMOST_FULL > LENGTH || ALMOST_EMPTY > LENGTH) begin : g_bad_thresh
        $error("fifo_flagged: ALMOST_FULL/ALMOST_EMPTY exceed LENGTH");
    end

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   count_q, count_d;
    flags_t          flags_q, flags_d;
    logic [ERR_W-1:0] err_q, err_d, new_err_s;
    logic            push_s, pop_s;
    logic [XLEN-1:0] mem_rdata_s;

    // Accept decisions: a full FIFO still takes a push when a pop frees the slot.
    always_comb begin
        push_s = bus.we && (!flags_q.full || bus.re);
        pop_s  = bus.re && !flags_q.empty;
    end

    // Next pointers, count, flags and sticky errors.
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + PW'(1);
            2'b01:   count_d = count_q - PW'(1);
            default: count_d = count_q;
        endcase
        flags_d = fifo_flags(32'(count_d), LENGTH, ALMOST_FULL, ALMOST_EMPTY);
        new_err_s              = '0;
        new_err_s[ERR_OVF_BIT] = bus.we && !push_s;
        new_err_s[ERR_UDF_BIT] = bus.re && flags_q.empty;
        err_d = new_err_s | (err_q & {ERR_W{~bus.clearErr}});
    end

    // Pointer, count, flag and error state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            flags_q  <= fifo_flags(32'd0, LENGTH, ALMOST_FULL, ALMOST_EMPTY);
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
        end
    end

    fifo_mem #(.XLEN(XLEN), .LENGTH(LENGTH), .AW(AW)) u_mem (
        .clk_i   (clk),
        .we_i    (push_s),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (bus.din),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (mem_rdata_s)
    );

    if (FWFT != 0) begin : g_fwft
        assign bus.dout   = mem_rdata_s;
        assign bus.dvalid = ~flags_q.empty;
    end else begin : g_regread
        logic [XLEN-1:0] dout_q;
        logic            dvalid_q;

        // Registered read: head captured on an accepted pop, valid for one cycle.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                dout_q   <= '0;
                dvalid_q <= 1'b0;
            end else begin
                dout_q   <= pop_s ? mem_rdata_s : dout_q;
                dvalid_q <= pop_s;
            end
        end

        assign bus.dout   = dout_q;
        assign bus.dvalid = dvalid_q;
    end

    assign bus.empty       = flags_q.empty;
    assign bus.full        = flags_q.full;
    assign bus.almostFull  = flags_q.almost_full;
    assign bus.almostEmpty = flags_q.almost_empty;
    assign bus.count       = count_q;
    assign bus.overflow    = err_q[ERR_OVF_BIT];
    assign bus.underflow   = err_q[ERR_UDF_BIT];

endmodule

// File: tb/tb_fifo_flagged.sv
// Bench for fifo_flagged: one FWFT and one registered-read instance driven in
// lockstep and compared every cycle against a queue-based model.
module tb_fifo_flagged;

    localparam int DEPTH = 4;
    localparam int AFULL = 3;
    localparam int AEMPT = 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fifo_flagged_if #(.XLEN(32), .CW(3)) if1 ();
    fifo_flagged_if #(.XLEN(32), .CW(3)) if0 ();

    fifo_flagged #(.XLEN(32), .LENGTH(DEPTH), .FWFT(1), .ALMOST_FULL(AFULL), .ALMOST_EMPTY(AEMPT))
        u_fwft (.clk(clk), .reset(reset), .bus(if1.slave));
    fifo_flagged #(.XLEN(32), .LENGTH(DEPTH), .FWFT(0), .ALMOST_FULL(AFULL), .ALMOST_EMPTY(AEMPT))
        u_reg (.clk(clk), .reset(reset), .bus(if0.slave));

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] q[$];
    bit          ovf_m = 1'b0;
    bit          udf_m = 1'b0;
    logic [31:0] dout0_m = 32'd0;
    bit          dvalid0_m = 1'b0;

    logic [31:0] words [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input bit w, input bit r, input logic [31:0] d, input bit c);
        if1.we = w; if1.re = r; if1.din = d; if1.clearErr = c;
        if0.we = w; if0.re = r; if0.din = d; if0.clearErr = c;
    endtask

    // Behavioural effect of one clock edge on the reference queue.
    task automatic model_edge(input bit w, input bit r, input logic [31:0] d, input bit c);
        int n;
        bit push_ok;
        bit pop_ok;
        n       = q.size();
        push_ok = w && (n < DEPTH || r);
        pop_ok  = r && (n > 0);
        dvalid0_m = pop_ok;
        if (pop_ok) dout0_m = q.pop_front();
        if (push_ok) q.push_back(d);
        ovf_m = (w && !push_ok) || (ovf_m && !c);
        udf_m = (r && n == 0) || (udf_m && !c);
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count1", 32'(if1.count), n);
        chk("count0", 32'(if0.count), n);
        chk("empty1", 32'(if1.empty), 32'(n == 0));
        chk("empty0", 32'(if0.empty), 32'(n == 0));
        chk("full1", 32'(if1.full), 32'(n == DEPTH));
        chk("full0", 32'(if0.full), 32'(n == DEPTH));
        chk("afull1", 32'(if1.almostFull), 32'(n >= AFULL));
        chk("aempty1", 32'(if1.almostEmpty), 32'(n <= AEMPT));
        chk("afull0", 32'(if0.almostFull), 32'(n >= AFULL));
        chk("aempty0", 32'(if0.almostEmpty), 32'(n <= AEMPT));
        chk("ovf1", 32'(if1.overflow), 32'(ovf_m));
        chk("udf1", 32'(if1.underflow), 32'(udf_m));
        chk("ovf0", 32'(if0.overflow), 32'(ovf_m));
        chk("udf0", 32'(if0.underflow), 32'(udf_m));
        chk("dvalid1", 32'(if1.dvalid), 32'(n != 0));
        if (n != 0) chk("dout1", if1.dout, q[0]);
        chk("dvalid0", 32'(if0.dvalid), 32'(dvalid0_m));
        chk("dout0", if0.dout, dout0_m);
    endtask

    task automatic step(input bit w, input bit r, input logic [31:0] d, input bit c);
        drive(w, r, d, c);
        @(posedge clk);
        model_edge(w, r, d, c);
        @(negedge clk);
        check_all();
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic reset_mid();
        #2;
        reset = 1'b0;
        #1;
        q.delete();
        ovf_m = 1'b0; udf_m = 1'b0; dout0_m = 32'd0; dvalid0_m = 1'b0;
        check_all();
        chk("rst_mid_count", 32'(if1.count), 32'd0);
        chk("rst_mid_empty", 32'(if1.empty), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        check_all();
    endtask

    initial begin
        words[0] = 32'hdeadbeef; words[1] = 32'hbababebe;
        words[2] = 32'hcacacaca; words[3] = 32'hfeedbeef;
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        check_all();
        chk("rst_empty", 32'(if1.empty), 32'd1);
        chk("rst_full", 32'(if1.full), 32'd0);
        chk("rst_aempty", 32'(if1.almostEmpty), 32'd1);
        chk("rst_dout0", if0.dout, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Underflow on empty, then clear.
        step(1'b0, 1'b1, 32'd0, 1'b0);
        chk("udf_set", 32'(if1.underflow), 32'd1);
        chk("udf_count", 32'(if1.count), 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("udf_clr", 32'(if1.underflow), 32'd0);

        // Fill and overflow.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, words[i], 1'b0);
            chk("fill_count", 32'(if1.count), 32'(i + 1));
        end
        chk("fill_full", 32'(if1.full), 32'd1);
        chk("fill_afull", 32'(if1.almostFull), 32'd1);
        step(1'b1, 1'b0, 32'h00000000, 1'b0);
        chk("ovf_count", 32'(if1.count), 32'd4);
        chk("ovf_set", 32'(if1.overflow), 32'd1);

        // Drain in order on both read modes.
        for (int i = 0; i < 4; i++) begin
            chk("drain_fwft", if1.dout, words[i]);
            step(1'b0, 1'b1, 32'd0, 1'b0);
            chk("drain_reg", if0.dout, words[i]);
            chk("drain_regv", 32'(if0.dvalid), 32'd1);
        end
        chk("drain_empty", 32'(if1.empty), 32'd1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("ovf_clr", 32'(if1.overflow), 32'd0);

        // Simultaneous push+pop while full.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, words[i], 1'b0);
        step(1'b1, 1'b1, 32'h01010101, 1'b0);
        chk("fullrw_count", 32'(if1.count), 32'd4);
        chk("fullrw_ovf", 32'(if1.overflow), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'd0, 1'b0);
        chk("fullrw_last", if1.dout, 32'h01010101);
        step(1'b0, 1'b1, 32'd0, 1'b0);

        // Registered-read latency.
        step(1'b1, 1'b0, 32'h11111111, 1'b0);
        chk("reg_novalid", 32'(if0.dvalid), 32'd0);
        step(1'b0, 1'b1, 32'd0, 1'b0);
        chk("reg_dout", if0.dout, 32'h11111111);
        chk("reg_valid", 32'(if0.dvalid), 32'd1);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        chk("reg_valid_drop", 32'(if0.dvalid), 32'd0);
        chk("reg_hold", if0.dout, 32'h11111111);

        // Asynchronous reset mid-burst.
        step(1'b1, 1'b0, 32'h22222222, 1'b0);
        step(1'b1, 1'b0, 32'h33333333, 1'b0);
        reset_mid();
        step(1'b1, 1'b0, 32'h5a5a5a5a, 1'b0);
        chk("post_rst_head", if1.dout, 32'h5a5a5a5a);

        // Randomised traffic.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset_mid();
            end else begin
                step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                     $urandom, $urandom_range(0, 15) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
